// File: rtl/lifo_pkg.sv
// Shared constants for the LIFO drain engine: FSM encoding, counter sizing, skid depth.
package lifo_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned SKID_CW    = $clog2(SKID_DEPTH + 1);

    // Length counter must hold the full LIFO capacity 2**depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return depth + 1;
    endfunction

endpackage

// File: rtl/lifo_skid_buf.sv
// Two-entry FIFO of {data, last} absorbing LIFO read latency and stream backpressure.
module lifo_skid_buf
    import lifo_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [N-1:0]       push_data,
    input  logic               push_last,
    input  logic               pop,
    output logic [N-1:0]       head_data,
    output logic               head_last,
    output logic [SKID_CW-1:0] count
);

    logic [N-1:0]       data_q [SKID_DEPTH];
    logic [N-1:0]       data_d [SKID_DEPTH];
    logic               last_q [SKID_DEPTH];
    logic               last_d [SKID_DEPTH];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [SKID_CW-1:0] count_q, count_d;

    always_comb begin
        data_d   = data_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            data_d[wr_ptr_q] = push_data;
            last_d[wr_ptr_q] = push_last;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = SKID_CW'(count_q + SKID_CW'(push) - SKID_CW'(pop));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(SKID_DEPTH); i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = data_q[rd_ptr_q];
    assign head_last = last_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/lifo_pop_stream.sv
// Drains up to req_len words from the LIFO onto a valid/ready stream, newest first.
// Optional pop counter output pop_total is enabled by LIFO_POP_STATS_EN.
module lifo_pop_stream
    import lifo_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned depth = 3,
    parameter int unsigned CNT_W = cnt_w(depth)
) (
`ifdef LIFO_POP_STATS_EN
    output logic [31:0]      pop_total,
`endif
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] req_len,
    output logic             busy,
    output logic             done,
    output logic             short_burst,
    output logic             lifo_rd_en,
    input  logic [N-1:0]     lifo_dout,
    input  logic             lifo_empty,
    output logic [N-1:0]     m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               inflight_q, inflight_d;
    logic               short_q, short_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SKID_CW-1:0] skid_cnt;
    logic               xfer_c;
    logic               credit_c;
    logic               rd_en_c;
    logic               cap_last_c;
    logic [2:0]         outstanding_c;

    assign m_valid = (skid_cnt != '0);
    assign xfer_c  = m_valid && m_ready;

    // A beat leaving this cycle frees its slot for a pop issued this cycle.
    assign outstanding_c = 3'(skid_cnt) - 3'(xfer_c) + 3'(inflight_q);
    assign credit_c      = (outstanding_c < 3'd2);
    assign cap_last_c    = (rem_q == '0) || lifo_empty;

    lifo_skid_buf #(.N(N)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (lifo_dout),
        .push_last (cap_last_c),
        .pop       (xfer_c),
        .head_data (m_data),
        .head_last (m_last),
        .count     (skid_cnt)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        short_d    = short_q;
        rd_en_c    = (state_q == ST_RUN) && (rem_q != '0) && !lifo_empty && credit_c;
        inflight_d = rd_en_c;
        if (rd_en_c) begin
            rem_d = CNT_W'(rem_q - CNT_W'(1));
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    short_d = 1'b0;
                    if (req_len != '0) begin
                        rem_d   = req_len;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if ((rem_q == '0) || lifo_empty) begin
                    state_d = ST_DRAIN;
                    if (rem_q != '0) begin
                        short_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if ((skid_cnt == '0) && !inflight_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            short_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            short_q    <= short_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign lifo_rd_en  = rd_en_c;
    assign busy        = busy_q;
    assign done        = done_q;
    assign short_burst = short_q;

`ifdef LIFO_POP_STATS_EN
    logic [31:0] pop_total_q, pop_total_d;

    always_comb begin
        pop_total_d = pop_total_q;
        if (rd_en_c) begin
            pop_total_d = 32'(pop_total_q + 32'd1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_total_q <= '0;
        end else begin
            pop_total_q <= pop_total_d;
        end
    end

    assign pop_total = pop_total_q;
`endif

endmodule

// File: tb/tb_lifo_pop_stream.sv
// Directed bench for lifo_pop_stream with a behavioural LIFO and a beat scoreboard.
module tb_lifo_pop_stream;

    localparam int unsigned N     = 32;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CNT_W = DEPTH + 1;

    typedef struct packed {
        logic [N-1:0] data;
        logic         last;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] req_len = '0;
    logic             busy, done, short_burst, lifo_rd_en;
    logic [N-1:0]     lifo_dout;
    logic             lifo_empty;
    logic [N-1:0]     m_data;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic             m_last;
`ifdef LIFO_POP_STATS_EN
    logic [31:0]      pop_total;
`endif

    logic             wr_en = 1'b0;
    logic [N-1:0]     wr_data = '0;
    logic [N-1:0]     mem [8];
    logic [3:0]       sp;

    always #5 clk = ~clk;

    lifo_pop_stream #(.N(N), .depth(DEPTH), .CNT_W(CNT_W)) dut (
`ifdef LIFO_POP_STATS_EN
        .pop_total   (pop_total),
`endif
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .req_len     (req_len),
        .busy        (busy),
        .done        (done),
        .short_burst (short_burst),
        .lifo_rd_en  (lifo_rd_en),
        .lifo_dout   (lifo_dout),
        .lifo_empty  (lifo_empty),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last)
    );

    // Behavioural LIFO: 1-cycle read latency, shares the reset.
    assign lifo_empty = (sp == 4'd0);
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp        <= 4'd0;
            lifo_dout <= '0;
        end else if (wr_en && (sp < 4'd8)) begin
            mem[sp[2:0]] <= wr_data;
            sp           <= 4'(sp + 4'd1);
        end else if (lifo_rd_en && (sp != 4'd0)) begin
            lifo_dout <= mem[3'(sp - 4'd1)];
            sp        <= 4'(sp - 4'd1);
        end
    end

    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           issued = 0;
    int           delivered = 0;
    int           done_cnt, rd_cnt, beat_cnt, first_rd_cyc, start_cyc;
    int           beat_cyc [$];
    beat_t        exp_q [$];
    logic [N-1:0] stk [$];
    logic         prev_stall = 1'b0;
    logic [N-1:0] prev_data = '0;
    logic         prev_last = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        beat_t b;
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (lifo_rd_en) begin
                issued++;
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(m_valid), 64'(1));
                chk("stall_data", 64'(m_data), 64'(prev_data));
                chk("stall_last", 64'(m_last), 64'(prev_last));
            end
            if (m_valid && m_ready) begin
                delivered++;
                beat_cnt++;
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(0), 64'(1));
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", 64'(m_data), 64'(b.data));
                    chk("beat_last", 64'(m_last), 64'(b.last));
                end
            end
            if (busy) chk("occupancy_le2", 64'((issued - delivered) <= 2), 64'(1));
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [N-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        stk.push_back(w);
        tick();
        wr_en = 1'b0;
    endtask

    // Launch a burst, model the expected beats, run to done, then check status.
    task automatic burst(input int req, input bit toggle, input int busy_req);
        int           take;
        logic         exp_short;
        logic [N-1:0] w;
        exp_short = (req > 0) && (req > int'(stk.size()));
        take = (req < int'(stk.size())) ? req : int'(stk.size());
        for (int i = 0; i < take; i++) begin
            w = stk.pop_back();
            exp_q.push_back('{data: w, last: (i == take - 1)});
        end
        done_cnt = 0; rd_cnt = 0; beat_cnt = 0; first_rd_cyc = -1;
        beat_cyc.delete();
        m_ready = 1'b1;
        start   = 1'b1;
        req_len = CNT_W'(req);
        tick();
        start_cyc = cyc;
        start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (done_cnt > 0) break;
            m_ready = toggle ? (c % 2 == 0) : 1'b1;
            if ((busy_req >= 0) && (c == 1)) begin
                start   = 1'b1;
                req_len = CNT_W'(busy_req);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("done_seen", 64'(done_cnt > 0), 64'(1));
        m_ready = 1'b1;
        start   = 1'b0;
        tick();
        chk("done_pulse", 64'(done_cnt), 64'(1));
        chk("short_burst", 64'(short_burst), 64'(exp_short));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        chk("busy_after", 64'(busy), 64'(0));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_rd_en", 64'(lifo_rd_en), 64'(0));
        reset = 1'b0;
        tick();
        chk("idle_done", 64'(done), 64'(0));
        chk("idle_short", 64'(short_burst), 64'(0));
        chk("idle_last", 64'(m_last), 64'(0));

        // Eight words, take three at full rate.
        for (int i = 1; i <= 8; i++) push_word(N'(i * 16));
        burst(3, 1'b0, -1);
        chk("first_pop_latency", 64'(first_rd_cyc), 64'(start_cyc + 1));
        chk("beat_count_3", 64'(beat_cnt), 64'(3));
        chk("beats_back_to_back", 64'(beat_cyc[2] - beat_cyc[0]), 64'(2));
        chk("words_remain", 64'(lifo_empty), 64'(0));

        // Remaining five with a stalling consumer.
        burst(5, 1'b1, -1);
        chk("beat_count_5", 64'(beat_cnt), 64'(5));
        chk("lifo_drained", 64'(lifo_empty), 64'(1));

        // Short burst: two words, four requested.
        push_word(32'hAAAA);
        push_word(32'hBBBB);
        burst(4, 1'b0, -1);
        chk("beat_count_short", 64'(beat_cnt), 64'(2));

        // Zero-length request.
        burst(0, 1'b0, -1);
        chk("zero_len_pops", 64'(rd_cnt), 64'(0));
        chk("zero_len_beats", 64'(beat_cnt), 64'(0));

        // Start against an empty LIFO.
        burst(2, 1'b0, -1);
        chk("empty_start_beats", 64'(beat_cnt), 64'(0));
        chk("empty_start_pops", 64'(rd_cnt), 64'(0));

        // Start while busy must not retarget the burst.
        for (int i = 1; i <= 6; i++) push_word(N'(i));
        burst(2, 1'b0, 5);
        chk("busy_start_beats", 64'(beat_cnt), 64'(2));
        chk("busy_start_pops", 64'(rd_cnt), 64'(2));

        // Reset with two words buffered and the consumer stalled.
        for (int i = 0; i < 4; i++) exp_q.push_back('{data: stk.pop_back(), last: (i == 3)});
        m_ready = 1'b0;
        start   = 1'b1;
        req_len = CNT_W'(4);
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("pre_reset_valid", 64'(m_valid), 64'(1));
        chk("pre_reset_buffered", 64'(issued - delivered), 64'(2));
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(m_valid), 64'(0));
        chk("async_rst_busy", 64'(busy), 64'(0));
        chk("async_rst_rd_en", 64'(lifo_rd_en), 64'(0));
        exp_q.delete();
        stk.delete();
        issued = 0;
        delivered = 0;
        prev_stall = 1'b0;
        repeat (2) tick();
        reset   = 1'b0;
        m_ready = 1'b1;
        tick();
        chk("post_rst_busy", 64'(busy), 64'(0));
        chk("post_rst_valid", 64'(m_valid), 64'(0));
        push_word(32'h77);
        push_word(32'h88);
        burst(2, 1'b0, -1);
        chk("post_rst_beats", 64'(beat_cnt), 64'(2));
`ifdef LIFO_POP_STATS_EN
        chk("pop_total", 64'(pop_total), 64'(issued));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lifo_pop_stream.md
Name: lifo_pop_stream

Overview:
Downstream drain engine for the team's `lifo` stack. On a `start` command it pops up to `req_len` words from the stack and presents them in pop order (newest first) on a valid/ready stream, marking the final word with `m_last`. It absorbs the stack's 1-cycle read latency and consumer backpressure with an internal 2-entry skid buffer.

Parameters:
- N, 32, data width; must match the LIFO `N`.
- depth, 3, LIFO address bits; LIFO capacity is 2**depth.
- CNT_W, depth+1, width of the length and remaining counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  burst request; sampled only in IDLE.
- req_len  in  CNT_W  words requested; sampled with `start`.
- busy  out  1  high in any state other than IDLE.
- done  out  1  1-cycle pulse at end of burst.
- short_burst  out  1  burst ended on `lifo_empty` before `req_len` words; valid with `done`, held until next accepted `start`.
- lifo_rd_en  out  1  pop strobe to the LIFO `rd_en`.
- lifo_dout  in  N  LIFO read data; valid the cycle after `lifo_rd_en`.
- lifo_empty  in  1  LIFO `empty` flag.
- m_data  out  N  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  final beat of burst.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; skid buffer and counters cleared; all outputs 0. Words already popped but not delivered are lost. The LIFO resets from the same reset.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start` with `req_len`>0 -> RUN; remaining := `req_len`; `short_burst` := 0.
  - `start` with `req_len`=0 -> DONE; no pop is issued.
  - `start` while not IDLE is ignored.
- RUN, pop issue: `lifo_rd_en`=1 iff remaining>0 AND !`lifo_empty` AND (buffer occupancy + in-flight) < 2. Each issue decrements remaining. At most one pop is in flight.
- RUN, exit: if remaining=0, or `lifo_empty` with no pop issued this cycle -> DRAIN. If `lifo_empty` caused the exit while remaining>0, set `short_burst`=1.
- Capture: the cycle after a pop, `lifo_dout` is written to the buffer tail.
  - The entry is tagged last if remaining=0 or `lifo_empty` is high in the capture cycle.
  - No other entry is ever tagged last.
- Stream handshake:
  - `m_valid` = buffer not empty; `m_data`/`m_last` come from the buffer head.
  - Transfer occurs on `m_valid`&`m_ready`.
  - While `m_valid`=1 and `m_ready`=0, `m_data`/`m_last` hold stable.
  - Simultaneous capture and transfer is allowed.
- DRAIN: no pops. When the buffer is empty and nothing is in flight -> DONE.
- Zero-beat short burst: `start` with the LIFO empty -> `short_burst`=1, no beats, no `m_last`.
- DONE: `done`=1 for exactly one cycle -> IDLE.
- Latency: `start` sampled at edge E -> `lifo_rd_en` high in the cycle after E -> first `m_valid` in the following cycle. Sustained throughput is 1 word/cycle with `m_ready`=1.
- Integration rule: the LIFO writer must hold `wr_en`=0 while `busy`=1; otherwise behaviour is undefined.

Optional Feature:
- Macro: `LIFO_POP_STATS_EN`.
- Defined:
  - adds output `pop_total` (32 bits), incremented on every `lifo_rd_en`;
  - wraps at 2**32;
  - cleared only by reset.
- Undefined: no port and no counter logic.

Decomposition:
- Package `lifo_pkg`:
  - FSM state encoding (IDLE/RUN/DRAIN/DONE);
  - CNT_W derivation constant;
  - skid depth constant (2).
- Sub-module `lifo_skid_buf`:
  - 2-entry FIFO of {data, last};
  - push/pop/count interface;
  - count drives the pop credit check.

Test Plan:
- Push 0x10..0x80 (8 words); start, `req_len`=3, `m_ready`=1 -> beats 0x80, 0x70, 0x60 on 3 consecutive cycles; `m_last` only on 0x60; `done` pulse; `short_burst`=0; 5 words remain.
- Continuing from that state, `req_len`=5 with `m_ready` toggling 1,0,1,0 -> beats 0x50, 0x40, 0x30, 0x20, 0x10 with no loss or duplicates; data stable while stalled; occupancy+in-flight never exceeds 2; `lifo_empty`=1 at end.
- Push 0xAAAA then 0xBBBB; `req_len`=4 -> beats 0xBBBB, 0xAAAA(`m_last`); `done`; `short_burst`=1.
- `req_len`=0 -> `done` one cycle after DONE entry; `lifo_rd_en` never asserted; `m_valid` stays 0. Separately, start with LIFO empty and `req_len`=2 -> `done`, `short_burst`=1, no beats.
- `start` asserted while `busy` -> ignored; `remaining` is unchanged.
- Assert `reset` mid-burst with 2 words buffered and `m_ready`=0 -> `m_valid`/`busy`/`lifo_rd_en` go to 0 immediately (asynchronously); after release, state=IDLE and a new burst works.
- With `LIFO_POP_STATS_EN` defined, after the above bursts -> `pop_total` equals the total number of pops issued since reset.
